// File: rtl/cpu_alu_muldiv.sv
// Execute-stage ALU with iterative RV32M-style multiply/divide.
// Single-cycle ops register their result at the accept edge. Multiply uses
// shift-add and divide uses restoring division, one bit per cycle. A FIX cycle
// at the end applies the sign correction.
module cpu_alu_muldiv #(
    parameter int XLEN             = 32,
    parameter int TAG_W            = 5,
    parameter int FAST_DIV_SPECIAL = 1
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [4:0]       i_op,
    input  logic [XLEN-1:0]  i_op1,
    input  logic [XLEN-1:0]  i_op2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_result,
    output logic             o_compare,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [4:0] OP_ADD    = 5'd0,  OP_SUB    = 5'd1,  OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3,  OP_XOR    = 5'd4,  OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6,  OP_SRA    = 5'd7,  OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9,  OP_EQ     = 5'd10, OP_NE   = 5'd11;
    localparam logic [4:0] OP_GE     = 5'd12, OP_GEU    = 5'd13;
    localparam logic [4:0] OP_MUL    = 5'd16, OP_MULH   = 5'd17, OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19, OP_DIV    = 5'd20, OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22, OP_REMU   = 5'd23;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t              r_state, w_next_state;
    logic                r_valid, r_compare;
    logic [XLEN-1:0]     r_result;
    logic [TAG_W-1:0]    r_tag_out, r_tag_pend;
    logic [4:0]          r_op;
    logic [CNT_W-1:0]    r_count;
    logic [2*XLEN-1:0]   r_acc;      // MUL: product; DIV: {remainder, quotient}
    logic [2*XLEN-1:0]   r_mcand;    // MUL: shifted multiplicand; DIV: divisor in low word
    logic [XLEN-1:0]     r_mplier;
    logic                r_neg_res, r_neg_rem;

    logic                w_accept, w_is_mul, w_is_div, w_is_cmp, w_fast;
    logic                w_op1_signed, w_op2_signed, w_op1_neg, w_op2_neg;
    logic                w_div_zero, w_div_ovf, w_alu_cmp;
    logic [XLEN-1:0]     w_mag1, w_mag2, w_alu_result, w_special, w_issue_result;
    logic [XLEN-1:0]     w_quo, w_rem, w_fix_result;
    logic [2*XLEN-1:0]   w_prod;
    logic [SH_W-1:0]     w_shamt;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   dvsr);
        logic [XLEN:0]   shifted;
        logic [XLEN-1:0] diff;
        logic            fits;
        shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        fits    = shifted >= {1'b0, dvsr};
        // Difference is below the divisor when it fits, so the low word is exact.
        diff    = shifted[XLEN-1:0] - dvsr;
        return {fits ? diff : shifted[XLEN-1:0], acc[XLEN-2:0], fits};
    endfunction

    assign o_ready   = (r_state == S_IDLE) && (!r_valid || i_ready);
    assign o_busy    = (r_state != S_IDLE);
    assign o_valid   = r_valid;
    assign o_result  = r_result;
    assign o_compare = r_compare;
    assign o_tag     = r_tag_out;

    assign w_accept = i_valid && o_ready;
    assign w_is_mul = (i_op[4:2] == 3'b100);
    assign w_is_div = (i_op[4:2] == 3'b101);
    assign w_is_cmp = (i_op >= OP_SLT) && (i_op <= OP_GEU);
    assign w_shamt  = i_op2[SH_W-1:0];

    // Operand sign handling: iterate on magnitudes, correct the sign in FIX.
    assign w_op1_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_op2_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_op1_neg    = w_op1_signed && i_op1[XLEN-1];
    assign w_op2_neg    = w_op2_signed && i_op2[XLEN-1];
    assign w_mag1       = w_op1_neg ? -i_op1 : i_op1;
    assign w_mag2       = w_op2_neg ? -i_op2 : i_op2;

    assign w_div_zero = (i_op2 == '0);
    assign w_div_ovf  = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                        (i_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_op2 == '1);
    assign w_fast     = (FAST_DIV_SPECIAL != 0) && w_is_div && (w_div_zero || w_div_ovf);
    // op[1] separates REM/REMU from DIV/DIVU.
    assign w_special  = w_div_zero ? (i_op[1] ? i_op1 : '1) : (i_op[1] ? '0 : i_op1);

    // Single-cycle ALU and compare unit.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_alu_result = '0;
        w_alu_cmp    = 1'b0;
        case (i_op)
            OP_ADD:  w_alu_result = i_op1 + i_op2;
            OP_SUB:  w_alu_result = i_op1 - i_op2;
            OP_AND:  w_alu_result = i_op1 & i_op2;
            OP_OR:   w_alu_result = i_op1 | i_op2;
            OP_XOR:  w_alu_result = i_op1 ^ i_op2;
            OP_SLL:  w_alu_result = i_op1 << w_shamt;
            OP_SRL:  w_alu_result = i_op1 >> w_shamt;
            OP_SRA:  w_alu_result = $unsigned($signed(i_op1) >>> w_shamt);
            OP_SLT:  w_alu_cmp    = $signed(i_op1) < $signed(i_op2);
            OP_SLTU: w_alu_cmp    = i_op1 < i_op2;
            OP_EQ:   w_alu_cmp    = i_op1 == i_op2;
            OP_NE:   w_alu_cmp    = i_op1 != i_op2;
            OP_GE:   w_alu_cmp    = $signed(i_op1) >= $signed(i_op2);
            OP_GEU:  w_alu_cmp    = i_op1 >= i_op2;
            default: ;
        endcase
        if (w_is_cmp) w_alu_result = {{(XLEN-1){1'b0}}, w_alu_cmp};
    end

    assign w_issue_result = w_fast ? w_special : w_alu_result;

    // Sign correction and word select for the finished iterative result.
    always_comb begin
        w_prod       = r_neg_res ? -r_acc : r_acc;
        w_quo        = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem        = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        w_fix_result = '0;
        case (r_op)
            OP_MUL:                       w_fix_result = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_fix_result = w_quo;
            OP_REM, OP_REMU:              w_fix_result = w_rem;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next_state;
    end

    // Next-state logic. The accept edge performs the first iteration, so MUL/DIV
    // run XLEN-1 more cycles before FIX.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (w_is_mul)                  w_next_state = S_MUL;
                else if (w_is_div && !w_fast)  w_next_state = S_DIV;
            end
            S_MUL, S_DIV: if (r_count == CNT_W'(XLEN-2)) w_next_state = S_FIX;
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: capture at accept, iterate, and register results.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            // NOTE: the iteration registers are reset too, so an abort leaves no stale partial result.
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_compare  <= 1'b0;
            r_tag_out  <= '0;
            r_tag_pend <= '0;
            r_op       <= '0;
            r_count    <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
        end else begin
            if (r_valid && i_ready) r_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op       <= i_op;
                    r_tag_pend <= i_tag;
                    r_count    <= '0;
                    if (w_is_mul) begin
                        r_acc     <= w_mag2[0] ? {{XLEN{1'b0}}, w_mag1} : '0;
                        r_mcand   <= {{(XLEN-1){1'b0}}, w_mag1, 1'b0};
                        r_mplier  <= w_mag2 >> 1;
                        r_neg_res <= w_op1_neg ^ w_op2_neg;
                    end else if (w_is_div && !w_fast) begin
                        r_acc     <= div_step({{XLEN{1'b0}}, w_mag1}, w_mag2);
                        r_mcand   <= {{XLEN{1'b0}}, w_mag2};
                        // Divide by zero keeps the all-ones quotient unnegated.
                        r_neg_res <= (w_op1_neg ^ w_op2_neg) && !w_div_zero;
                        r_neg_rem <= w_op1_neg;
                    end else begin
                        r_valid   <= 1'b1;
                        r_result  <= w_issue_result;
                        r_compare <= w_is_cmp && w_alu_cmp;
                        r_tag_out <= i_tag;
                    end
                end
                S_MUL: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_W'(1);
                end
                S_DIV: begin
                    r_acc   <= div_step(r_acc, r_mcand[XLEN-1:0]);
                    r_count <= r_count + CNT_W'(1);
                end
                S_FIX: begin
                    r_valid   <= 1'b1;
                    r_result  <= w_fix_result;
                    r_compare <= 1'b0;
                    r_tag_out <= r_tag_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_alu_muldiv.sv
// Self-checking bench for cpu_alu_muldiv (XLEN=32): vector table, streaming
// with back-pressure, and reset abort during a divide.
module tb_cpu_alu_muldiv;

    logic        i_clock, i_reset_n, i_valid, i_ready;
    logic        o_ready, o_valid, o_compare, o_busy;
    logic [4:0]  i_op, i_tag, o_tag;
    logic [31:0] i_op1, i_op2, o_result;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cmp;
        int          lat;
    } vec_t;

    vec_t vq[$];

    cpu_alu_muldiv #(.XLEN(32), .TAG_W(5), .FAST_DIV_SPECIAL(1)) dut (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_op1     (i_op1),
        .i_op2     (i_op2),
        .i_tag     (i_tag),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_compare (o_compare),
        .o_tag     (o_tag),
        .o_busy    (o_busy)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic add_vec(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic cmp,
                           input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.cmp = cmp; v.lat = lat;
        vq.push_back(v);
    endtask

    // Issue one op with i_ready=1, then check result, compare, tag, latency and busy.
    task automatic run_vec(input int idx);
        vec_t v;
        int   lat;
        int   bad_busy;
        logic [4:0] tag;
        v   = vq[idx];
        tag = idx[4:0];
        i_op = v.op; i_op1 = v.a; i_op2 = v.b; i_tag = tag; i_ready = 1'b1; i_valid = 1'b1;
        #1;
        check($sformatf("%s ready", v.name), {31'd0, o_ready}, 32'd1);
        @(posedge i_clock); #1;
        i_valid = 1'b0; i_op = 5'd0; i_op1 = ~v.a; i_op2 = ~v.b; i_tag = ~tag;
        lat = 1;
        bad_busy = 0;
        while (!o_valid && lat < 40) begin
            if (!o_busy || o_ready) bad_busy++;
            @(posedge i_clock); #1;
            lat++;
        end
        if (o_busy) bad_busy++;
        check($sformatf("%s result", v.name),  o_result, v.res);
        check($sformatf("%s compare", v.name), {31'd0, o_compare}, {31'd0, v.cmp});
        check($sformatf("%s tag", v.name),     {27'd0, o_tag}, {27'd0, tag});
        check($sformatf("%s latency", v.name), lat, v.lat);
        check($sformatf("%s busy/ready", v.name), bad_busy, 0);
        @(posedge i_clock); #1;
        check($sformatf("%s valid drop", v.name), {31'd0, o_valid}, 32'd0);
    endtask

    // Stream four ADDs; pat[cyc%4] drives i_ready. Returns cycles between first and last accept.
    task automatic run_stream(input logic [3:0] pat, input int base_tag, output int span);
        logic [31:0] sa[4];
        logic [31:0] sb[4];
        logic [31:0] se[4];
        int   sent, got, first, last;
        logic held;
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        sa = '{32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 32'h1234_5678};
        sb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0020, 32'h8765_4321};
        se = '{32'h0000_0002, 32'h8000_0000, 32'h0000_0010, 32'h9999_9999};
        sent = 0; got = 0; first = -1; last = -1; held = 1'b0;
        held_res = '0; held_tag = '0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            i_ready = pat[cyc % 4];
            i_valid = (sent < 4);
            i_op    = 5'd0;
            i_op1   = (sent < 4) ? sa[sent] : 32'd0;
            i_op2   = (sent < 4) ? sb[sent] : 32'd0;
            i_tag   = 5'(base_tag + sent);
            #1;
            if (held) begin
                check("stall valid held", {31'd0, o_valid}, 32'd1);
                check("stall result held", o_result, held_res);
                check("stall tag held", {27'd0, o_tag}, {27'd0, held_tag});
            end
            held     = o_valid && !i_ready;
            held_res = o_result;
            held_tag = o_tag;
            if (o_valid && i_ready) begin
                check($sformatf("stream result %0d", got), o_result, se[got]);
                check($sformatf("stream tag %0d", got), {27'd0, o_tag}, 32'(base_tag + got));
                got++;
            end
            if (i_valid && o_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                sent++;
            end
            @(posedge i_clock); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("stream results received", got, 4);
        check("stream no duplicate", {31'd0, o_valid}, 32'd0);
        span = last - first;
    endtask

    initial begin
        int span;
        int seen;

        add_vec("ADD wrap",      5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        add_vec("SUB",           5'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1);
        add_vec("AND",           5'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
        add_vec("OR",            5'd3,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1);
        add_vec("XOR",           5'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
        add_vec("SLL by 35",     5'd5,  32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 1'b0, 1);
        add_vec("SRL by 31",     5'd6,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1);
        add_vec("SRA by 36",     5'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1);
        add_vec("SLT -1<1",      5'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1);
        add_vec("SLTU 1<max",    5'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1);
        add_vec("EQ",            5'd10, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1'b1, 1);
        add_vec("NE equal",      5'd11, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1);
        add_vec("GE same",       5'd12, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 1'b1, 1);
        add_vec("GEU 1>=max",    5'd13, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1);
        add_vec("unknown 14",    5'd14, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b0, 1);
        add_vec("unknown 31",    5'd31, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b0, 1);
        add_vec("MUL 7*-3",      5'd16, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
        add_vec("MULH min*min",  5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
        add_vec("MULHSU -1*max", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
        add_vec("MULHU max*max", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        add_vec("MULHU 2^31*4",  5'd19, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 1'b0, 33);
        add_vec("DIV -7/2",      5'd20, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33);
        add_vec("REM -7/2",      5'd22, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33);
        add_vec("DIV 20/-3",     5'd20, 32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0, 33);
        add_vec("REM 20/-3",     5'd22, 32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002, 1'b0, 33);
        add_vec("DIVU 100/7",    5'd21, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 33);
        add_vec("REMU 100/7",    5'd23, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 33);
        add_vec("DIVU x/0",      5'd21, 32'h0000_3039, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1);
        add_vec("DIV -7/0",      5'd20, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1);
        add_vec("REM x/0",       5'd22, 32'h0000_3039, 32'h0000_0000, 32'h0000_3039, 1'b0, 1);
        add_vec("DIV overflow",  5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        add_vec("REM overflow",  5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1);

        i_reset_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_op = '0; i_op1 = '0; i_op2 = '0; i_tag = '0;
        #12;
        check("reset o_valid",   {31'd0, o_valid},   32'd0);
        check("reset o_busy",    {31'd0, o_busy},    32'd0);
        check("reset o_result",  o_result,           32'd0);
        check("reset o_compare", {31'd0, o_compare}, 32'd0);
        check("reset o_tag",     {27'd0, o_tag},     32'd0);
        @(posedge i_clock); #3;
        i_reset_n = 1'b1;
        @(posedge i_clock); #1;

        for (int i = 0; i < vq.size(); i++) run_vec(i);

        run_stream(4'b1001, 20, span);
        run_stream(4'b1111, 24, span);
        check("stream 1 op/cycle span", span, 3);

        // Reset abort in the middle of a divide.
        run_vec(3);
        i_op = 5'd20; i_op1 = 32'd1000; i_op2 = 32'd3; i_tag = 5'd9; i_valid = 1'b1;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        repeat (8) @(posedge i_clock);
        #2;
        check("pre-abort busy", {31'd0, o_busy}, 32'd1);
        i_reset_n = 1'b0;
        #1;
        check("abort o_valid",   {31'd0, o_valid},   32'd0);
        check("abort o_busy",    {31'd0, o_busy},    32'd0);
        check("abort o_result",  o_result,           32'd0);
        check("abort o_compare", {31'd0, o_compare}, 32'd0);
        check("abort o_tag",     {27'd0, o_tag},     32'd0);
        repeat (2) @(posedge i_clock);
        #3;
        i_reset_n = 1'b1;
        @(posedge i_clock); #1;
        seen = 0;
        repeat (40) begin
            if (o_valid) seen++;
            @(posedge i_clock); #1;
        end
        check("no result after abort", seen, 0);
        run_vec(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
